// File: rtl/ysyx_210544_wb_queue_if.sv
// Write-back queue bus: memory-stage producer side, write-back consumer side, flush and status.
// Optional forwarding lookup ports are present when YSYX_210544_WB_FWD_EN is defined.
interface ysyx_210544_wb_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            i_wb_memoryed_req;
    logic            o_wb_memoryed_ack;
    logic [63:0]     i_wb_pc;
    logic [31:0]     i_wb_inst;
    logic [4:0]      i_wb_rd;
    logic            i_wb_rd_wen;
    logic [63:0]     i_wb_rd_wdata;
    logic            i_wb_skipcmt;
    logic [31:0]     i_wb_intrNo;

    logic            o_wb_writebacked_req;
    logic            i_wb_writebacked_ack;
    logic [63:0]     o_wb_pc;
    logic [31:0]     o_wb_inst;
    logic [4:0]      o_wb_rd;
    logic            o_wb_rd_wen;
    logic [63:0]     o_wb_rd_wdata;
    logic            o_wb_skipcmt;
    logic [31:0]     o_wb_intrNo;

    logic            i_wb_flush;
    logic [CW-1:0]   o_wb_count;
    logic [CNT_W-1:0] o_wb_commit_cnt;
`ifdef YSYX_210544_WB_FWD_EN
    logic [4:0]      i_wb_fwd_rs;
    logic            o_wb_fwd_hit;
    logic [63:0]     o_wb_fwd_data;
`endif

    modport slave (
        input  i_wb_memoryed_req, i_wb_pc, i_wb_inst, i_wb_rd, i_wb_rd_wen,
               i_wb_rd_wdata, i_wb_skipcmt, i_wb_intrNo,
               i_wb_writebacked_ack, i_wb_flush,
`ifdef YSYX_210544_WB_FWD_EN
               i_wb_fwd_rs,
        output o_wb_fwd_hit, o_wb_fwd_data,
`endif
        output o_wb_memoryed_ack, o_wb_writebacked_req, o_wb_pc, o_wb_inst, o_wb_rd,
               o_wb_rd_wen, o_wb_rd_wdata, o_wb_skipcmt, o_wb_intrNo,
               o_wb_count, o_wb_commit_cnt
    );

    modport master (
        output i_wb_memoryed_req, i_wb_pc, i_wb_inst, i_wb_rd, i_wb_rd_wen,
               i_wb_rd_wdata, i_wb_skipcmt, i_wb_intrNo,
               i_wb_writebacked_ack, i_wb_flush,
`ifdef YSYX_210544_WB_FWD_EN
               i_wb_fwd_rs,
        input  o_wb_fwd_hit, o_wb_fwd_data,
`endif
        input  o_wb_memoryed_ack, o_wb_writebacked_req, o_wb_pc, o_wb_inst, o_wb_rd,
               o_wb_rd_wen, o_wb_rd_wdata, o_wb_skipcmt, o_wb_intrNo,
               o_wb_count, o_wb_commit_cnt
    );
endinterface

// File: rtl/ysyx_210544_wb_queue.sv
// Circular write-back queue between memory and write-back stages, with flush and commit counter.
// Define YSYX_210544_WB_FWD_EN to add a combinational rd-forwarding lookup over queued entries.
module ysyx_210544_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_210544_wb_queue_if.slave wb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] rd_wdata;
        logic        skipcmt;
        logic [31:0] intr_no;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] commit_cnt;

    logic   ack_c;
    logic   head_vld_c;
    logic   push_c;
    logic   pop_c;
    entry_t head_c;
    entry_t in_c;

    assign ack_c      = (count != CW'(DEPTH)) & ~wb.i_wb_flush;
    assign head_vld_c = (count != '0);
    assign push_c     = wb.i_wb_memoryed_req & ack_c;
    assign pop_c      = head_vld_c & wb.i_wb_writebacked_ack;
    assign head_c     = mem[rd_ptr];
    assign in_c       = '{pc: wb.i_wb_pc, inst: wb.i_wb_inst, rd: wb.i_wb_rd,
                          rd_wen: wb.i_wb_rd_wen, rd_wdata: wb.i_wb_rd_wdata,
                          skipcmt: wb.i_wb_skipcmt, intr_no: wb.i_wb_intrNo};

    // Head payload is masked to zero while the queue is empty.
    assign wb.o_wb_memoryed_ack    = ack_c;
    assign wb.o_wb_writebacked_req = head_vld_c;
    assign wb.o_wb_pc              = head_vld_c ? head_c.pc       : '0;
    assign wb.o_wb_inst            = head_vld_c ? head_c.inst     : '0;
    assign wb.o_wb_rd              = head_vld_c ? head_c.rd       : '0;
    assign wb.o_wb_rd_wen          = head_vld_c ? head_c.rd_wen   : 1'b0;
    assign wb.o_wb_rd_wdata        = head_vld_c ? head_c.rd_wdata : '0;
    assign wb.o_wb_skipcmt         = head_vld_c ? head_c.skipcmt  : 1'b0;
    assign wb.o_wb_intrNo          = head_vld_c ? head_c.intr_no  : '0;
    assign wb.o_wb_count           = count;
    assign wb.o_wb_commit_cnt      = commit_cnt;

    // Pointer, occupancy and commit bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            commit_cnt <= '0;
        end else if (wb.i_wb_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            if (push_c && !pop_c)      count <= count + CW'(1);
            else if (pop_c && !push_c) count <= count - CW'(1);
            if (pop_c && !head_c.skipcmt) commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= in_c;
    end

`ifdef YSYX_210544_WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        wb.o_wb_fwd_hit  = 1'b0;
        wb.o_wb_fwd_data = '0;
        fwd_idx          = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && mem[fwd_idx].rd_wen && (mem[fwd_idx].rd != '0) &&
                (mem[fwd_idx].rd == wb.i_wb_fwd_rs)) begin
                wb.o_wb_fwd_hit  = 1'b1;
                wb.o_wb_fwd_data = mem[fwd_idx].rd_wdata;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_210544_wb_queue.sv
// Randomized bench for ysyx_210544_wb_queue against a queue-based reference model.
module tb_ysyx_210544_wb_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 32;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        skip;
        logic [31:0] intr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ent_t        model[$];
    logic [31:0] commit_m = '0;

    always #5 clk = ~clk;

    ysyx_210544_wb_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) wb ();

    ysyx_210544_wb_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.pc   = {$urandom, $urandom};
        e.inst = $urandom;
        e.rd   = 5'($urandom_range(0, 7));
        e.wen  = 1'($urandom);
        e.data = {$urandom, $urandom};
        e.skip = 1'($urandom);
        e.intr = $urandom;
        return e;
    endfunction

    task automatic drive(input logic req, input logic ack, input logic flush, input ent_t e);
        wb.i_wb_memoryed_req    = req;
        wb.i_wb_writebacked_ack = ack;
        wb.i_wb_flush           = flush;
        wb.i_wb_pc              = e.pc;
        wb.i_wb_inst            = e.inst;
        wb.i_wb_rd              = e.rd;
        wb.i_wb_rd_wen          = e.wen;
        wb.i_wb_rd_wdata        = e.data;
        wb.i_wb_skipcmt         = e.skip;
        wb.i_wb_intrNo          = e.intr;
    endtask

    task automatic check_outputs();
        int   n;
        ent_t h;
        n = model.size();
        h = '{default: '0};
        if (n != 0) h = model[0];
        check("count",  64'(wb.o_wb_count), 64'(n));
        check("req",    64'(wb.o_wb_writebacked_req), 64'(n != 0));
        check("ack",    64'(wb.o_wb_memoryed_ack), 64'((n != int'(DEPTH)) && !wb.i_wb_flush));
        check("pc",     wb.o_wb_pc, h.pc);
        check("inst",   64'(wb.o_wb_inst), 64'(h.inst));
        check("rd",     64'(wb.o_wb_rd), 64'(h.rd));
        check("wen",    64'(wb.o_wb_rd_wen), 64'(h.wen));
        check("wdata",  wb.o_wb_rd_wdata, h.data);
        check("skip",   64'(wb.o_wb_skipcmt), 64'(h.skip));
        check("intr",   64'(wb.o_wb_intrNo), 64'(h.intr));
        check("commit", 64'(wb.o_wb_commit_cnt), 64'(commit_m));
`ifdef YSYX_210544_WB_FWD_EN
        begin
            logic        hit;
            logic [63:0] fd;
            hit = 1'b0;
            fd  = '0;
            foreach (model[i]) begin
                if (model[i].wen && model[i].rd != 5'd0 && model[i].rd == wb.i_wb_fwd_rs) begin
                    hit = 1'b1;
                    fd  = model[i].data;
                end
            end
            check("fwd_hit",  64'(wb.o_wb_fwd_hit), 64'(hit));
            check("fwd_data", wb.o_wb_fwd_data, fd);
        end
`endif
    endtask

    // One clock: decide push/pop from the model, advance it at the edge, compare after.
    task automatic step();
        int   n;
        logic push, pop, flush;
        ent_t e;
        n     = model.size();
        flush = wb.i_wb_flush;
        push  = wb.i_wb_memoryed_req && (n != int'(DEPTH)) && !flush;
        pop   = wb.i_wb_writebacked_ack && (n != 0);
        e = '{pc: wb.i_wb_pc, inst: wb.i_wb_inst, rd: wb.i_wb_rd, wen: wb.i_wb_rd_wen,
              data: wb.i_wb_rd_wdata, skip: wb.i_wb_skipcmt, intr: wb.i_wb_intrNo};
        @(posedge clk);
        if (flush) begin
            model.delete();
        end else begin
            if (pop) begin
                if (!model[0].skip) commit_m = commit_m + 32'd1;
                void'(model.pop_front());
            end
            if (push) model.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic push_n(input int k, input logic skip);
        ent_t e;
        for (int i = 0; i < k; i++) begin
            e = rand_ent();
            e.skip = skip;
            drive(1'b1, 1'b0, 1'b0, e);
            step();
        end
    endtask

    ent_t        e0;
    logic [31:0] base;

    initial begin
        e0 = '{default: '0};
        drive(1'b0, 1'b0, 1'b0, e0);
`ifdef YSYX_210544_WB_FWD_EN
        wb.i_wb_fwd_rs = 5'd0;
`endif
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // first push visible at head one cycle later
        e0 = rand_ent();
        e0.pc = 64'h8000_0000;
        drive(1'b1, 1'b0, 1'b0, e0);
        step();
        check("first_pc", wb.o_wb_pc, 64'h8000_0000);
        check("first_cnt", 64'(wb.o_wb_count), 64'd1);

        // fill to full; fifth request refused; drain in order
        drive(1'b0, 1'b0, 1'b1, e0);
        step();
        push_n(5, 1'b0);
        drive(1'b0, 1'b0, 1'b0, e0);
        #1;
        check("full_cnt", 64'(wb.o_wb_count), 64'(DEPTH));
        check("full_ack", 64'(wb.o_wb_memoryed_ack), 64'd0);
        e0 = rand_ent();
        drive(1'b1, 1'b1, 1'b0, e0);
        step();
        check("full_pushpop_cnt", 64'(wb.o_wb_count), 64'(DEPTH - 1));
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 1'b1, 1'b0, e0);
            step();
        end

        // steady push+pop at count 2 across pointer wrap
        push_n(2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, rand_ent());
            step();
            check("steady_cnt", 64'(wb.o_wb_count), 64'd2);
        end

        // flush beats concurrent push and pop
        drive(1'b0, 1'b0, 1'b1, e0);
        step();
        push_n(3, 1'b0);
        drive(1'b1, 1'b1, 1'b1, rand_ent());
        step();
        check("flush_cnt", 64'(wb.o_wb_count), 64'd0);
        check("flush_req", 64'(wb.o_wb_writebacked_req), 64'd0);
        check("flush_pc",  wb.o_wb_pc, 64'd0);

        // commit counter skips entries flagged skipcmt
        base = wb.o_wb_commit_cnt;
        push_n(1, 1'b0);
        push_n(1, 1'b1);
        push_n(1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, e0);
            step();
        end
        check("commit_delta", 64'(wb.o_wb_commit_cnt - base), 64'd2);

`ifdef YSYX_210544_WB_FWD_EN
        // youngest matching rd wins
        e0 = rand_ent(); e0.rd = 5'd5; e0.wen = 1'b1; e0.data = 64'h11;
        drive(1'b1, 1'b0, 1'b0, e0); step();
        e0.data = 64'h22;
        drive(1'b1, 1'b0, 1'b0, e0); step();
        drive(1'b0, 1'b0, 1'b0, e0);
        wb.i_wb_fwd_rs = 5'd5;
        #1;
        check("fwd5_hit",  64'(wb.o_wb_fwd_hit), 64'd1);
        check("fwd5_data", wb.o_wb_fwd_data, 64'h22);
        wb.i_wb_fwd_rs = 5'd0;
        #1;
        check("fwd0_hit",  64'(wb.o_wb_fwd_hit), 64'd0);
        @(negedge clk);
`endif

        // randomized traffic with occasional flush and mid-run reset
        for (int c = 0; c < 3000; c++) begin
            drive(1'(($urandom % 4) != 0), 1'($urandom % 2), 1'(($urandom % 40) == 0), rand_ent());
`ifdef YSYX_210544_WB_FWD_EN
            wb.i_wb_fwd_rs = 5'($urandom_range(0, 7));
`endif
            if (($urandom % 250) == 0) begin
                rst = 1'b0;
                #1;
                model.delete();
                commit_m = '0;
                check_outputs();
                @(negedge clk);
                rst = 1'b1;
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_210544_wb_queue.md
YSYX_210544_WB_QUEUE -- requirements
Module: ysyx_210544_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 32, width of the commit counter.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_wb_memoryed_req  in  1  upstream entry valid.
REQ-006 o_wb_memoryed_ack  out  1  queue can accept an entry.
REQ-007 i_wb_pc/i_wb_inst/i_wb_rd/i_wb_rd_wen/i_wb_rd_wdata/i_wb_skipcmt/i_wb_intrNo  in  64/32/5/1/64/1/32  entry payload.
REQ-008 o_wb_writebacked_req  out  1  head entry valid.
REQ-009 i_wb_writebacked_ack  in  1  downstream consumes head.
REQ-010 o_wb_pc/o_wb_inst/o_wb_rd/o_wb_rd_wen/o_wb_rd_wdata/o_wb_skipcmt/o_wb_intrNo  out  64/32/5/1/64/1/32  head payload.
REQ-011 i_wb_flush  in  1  discard all entries.
REQ-012 o_wb_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-013 o_wb_commit_cnt  out  CNT_W  total entries popped with skipcmt=0.

Function
REQ-014 Circular buffer of DEPTH entries, read/write pointers; push = i_wb_memoryed_req & o_wb_memoryed_ack; pop = o_wb_writebacked_req & i_wb_writebacked_ack.
REQ-015 o_wb_memoryed_ack SHALL equal (count != DEPTH) & !i_wb_flush; no same-cycle push into a full queue even when popping.
REQ-016 o_wb_writebacked_req SHALL equal (count != 0).
REQ-017 Latency: a pushed entry SHALL appear at the head one cycle after the push edge when the queue was empty.
REQ-018 Head payload outputs SHALL be zero when count is 0, else the oldest entry, unmodified.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 i_wb_flush SHALL take priority: next cycle count=0, pointers=0, push and pop both ignored; commit counter unaffected.
REQ-022 o_wb_commit_cnt SHALL increment by 1 on each pop whose head skipcmt is 0, wrapping modulo 2^CNT_W.
REQ-023 Order SHALL be strictly FIFO; no entry lost or duplicated.

Reset
REQ-024 On rst low, asynchronously: pointers, count, o_wb_commit_cnt SHALL be 0; o_wb_memoryed_ack SHALL be 1; o_wb_writebacked_req and all head outputs SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all entries; entry storage need not be cleared.

Configuration
REQ-026 Macro YSYX_210544_WB_FWD_EN, when defined, SHALL add ports i_wb_fwd_rs (in, 5), o_wb_fwd_hit (out, 1), o_wb_fwd_data (out, 64).
REQ-027 With the macro, o_wb_fwd_hit SHALL be 1 when any valid entry has rd_wen=1, rd=i_wb_fwd_rs and rd!=0; o_wb_fwd_data SHALL be that of the youngest match, else 0; purely combinational.
REQ-028 Without the macro, the ports and lookup logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, then push pc=0x80000000 with no ack -> next cycle req=1, o_wb_pc=0x80000000, count=1.
REQ-030 DEPTH=4: push 4 entries, ack held 0 -> count=4, memoryed_ack=0; 5th request not stored; pop all -> order preserved.
REQ-031 Push and pop every cycle for 10 cycles at count=2 -> count stays 2, pointers wrap, outputs in order.
REQ-032 count=3, assert flush with concurrent push -> next cycle count=0, req=0, all head outputs 0.
REQ-033 Pop 3 entries with skipcmt=0,1,0 -> o_wb_commit_cnt=2.
REQ-034 FWD_EN: entries rd=5 data 0x11 then rd=5 data 0x22, rs=5 -> hit=1, data=0x22; rs=0 -> hit=0.
